store_packer: RTL
=================

// Module: store_packer
// PURPOSE
//   Store-side counterpart of the immediate/load extender: narrows a 32-bit GPR value to
//   word/half/byte, lane-replicates it, generates byte enables and a word-aligned address.
//   Sits between the M-stage store path and the bridge/DM bus, with a one-entry holding
//   register and valid/ready handshakes on both sides.
//   Raises AdES (store address error) instead of issuing illegal stores.
// PARAMETERS
//   DM_LIMIT   32'h0000_2FFF  last byte address of data memory (DM base is 0)
//   DEV_BASE   32'h0000_7F00  first byte address of device (timer) space
//   DEV_LIMIT  32'h0000_7F1B  last byte address of device space
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   req_valid  in   1   store request present
//   req_ready  out  1   request accepted when req_valid & req_ready
//   st_op      in   2   0=sw 1=sh 2=sb 3=reserved
//   addr       in   32  byte address
//   wdata_in   in   32  GPR[rt] value
//   bus_valid  out  1   bus write pending
//   bus_ready  in   1   bus accepts write when bus_valid & bus_ready
//   bus_addr   out  32  {addr[31:2],2'b00}
//   bus_be     out  4   byte enables, bit i = byte lane i (bits 8i+7:8i)
//   bus_wdata  out  32  lane-replicated store data
//   exc_ades   out  1   one-cycle pulse, store address error
//   exc_addr   out  32  faulting byte address (valid while exc_ades=1)
// BEHAVIOUR
//   Reset: state=IDLE; bus_valid=0, bus_addr=0, bus_be=0, bus_wdata=0, exc_ades=0,
//     exc_addr=0. Asynchronous: assertion mid-PEND drops bus_valid immediately, store lost.
//   States: IDLE (no pending write), PEND (bus_valid=1, outputs held).
//   req_ready = (state==IDLE) | bus_ready  (combinational; accept in the same cycle as drain).
//   Accept (req_valid & req_ready) evaluates legality on that cycle's inputs:
//     illegal if: st_op==3; sw & addr[1:0]!=0; sh & addr[0]!=0;
//       addr outside [0,DM_LIMIT] and outside [DEV_BASE,DEV_LIMIT];
//       sh or sb with addr in device range (device space is word-only).
//   Legal accept -> next edge: state=PEND, bus_valid=1, registered outputs:
//     sw: be=4'b1111, wdata=wdata_in
//     sh: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata_in[15:0]}}
//     sb: be=4'b0001<<addr[1:0],      wdata={4{wdata_in[7:0]}}
//   Illegal accept -> next edge: exc_ades=1 for exactly one cycle, exc_addr=addr;
//     no bus write; state=IDLE (PEND drained by the same-cycle bus_ready also ends).
//   Latency: accept to bus_valid = 1 cycle. bus_addr/be/wdata stable while
//     bus_valid & !bus_ready (no change without handshake).
//   PEND & bus_ready & !accept -> IDLE, bus_valid=0 next cycle; bus_be/wdata hold last value.
//   PEND & bus_ready & legal accept -> stay PEND, new outputs (back-to-back, 1 store/cycle).
//   PEND & !bus_ready: req_ready=0, requests stall; nothing is dropped.
//   exc_ades is 0 in every cycle not directly following an illegal accept.
//   Boundaries DM_LIMIT, DEV_BASE, DEV_LIMIT are inclusive; compare full 32-bit addr.
// TESTING
//   1 sw addr=0x10 wdata=0xDEADBEEF, bus_ready=1 -> next cycle bus_valid=1,
//     bus_addr=0x10, be=1111, wdata=0xDEADBEEF; following cycle bus_valid=0.
//   2 sb addr=0x13 wdata=0x123456AB -> be=1000, wdata=0xABABABAB, bus_addr=0x10;
//     sh addr=0x22 wdata=0x0000CAFE -> be=1100, wdata=0xCAFECAFE, bus_addr=0x20.
//   3 sw addr=0x6, sh addr=0x5, sb addr=0x3000, sb addr=0x7F04, st_op=3 -> each gives one
//     exc_ades pulse, exc_addr=request addr, bus_valid stays 0.
//   4 sw 0x7F00 with bus_ready=0 for 3 cycles then 1 -> bus_valid/addr/be/wdata constant for
//     4 cycles, req_ready=0 for the first 3; a second queued sw issues the cycle after.
//   5 continuous sw stream addr 0x0,0x4,0x8 with bus_ready=1 -> one bus write per cycle,
//     no gaps, correct order; boundary sw 0x2FFC legal, sw 0x3000 faults.
//   6 reset asserted mid-PEND between edges -> bus_valid=0 at once, all outputs 0,
//     req_ready=1 after release, next legal sw issues normally.

Source files
------------

// File: rtl/store_packer.sv
// rtl/store_packer.sv - store-side narrowing, lane replication, byte enables and AdES detection
// One-entry holding register between the M-stage store path and the data/device bus.
module store_packer #(
   parameter logic [31:0] DM_LIMIT  = 32'h0000_2FFF,
   parameter logic [31:0] DEV_BASE  = 32'h0000_7F00,
   parameter logic [31:0] DEV_LIMIT = 32'h0000_7F1B
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  st_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata_in,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   output logic        exc_ades,
   output logic [31:0] exc_addr
);

   localparam logic [1:0] OP_SW = 2'd0;
   localparam logic [1:0] OP_SH = 2'd1;
   localparam logic [1:0] OP_SB = 2'd2;

   typedef enum logic {IDLE, PEND} state_t;

   state_t      state;
   logic        accept;
   logic        legal;
   logic        in_dm;
   logic        in_dev;
   logic [3:0]  next_be;
   logic [31:0] next_wdata;

   assign req_ready = (state == IDLE) | bus_ready;
   assign accept    = req_valid & req_ready;

   assign in_dm  = (addr <= DM_LIMIT);
   assign in_dev = (addr >= DEV_BASE) && (addr <= DEV_LIMIT);

   always_comb begin
      legal = 1'b1;
      if (st_op == 2'd3)
         legal = 1'b0;
      if ((st_op == OP_SW) && (addr[1:0] != 2'b00))
         legal = 1'b0;
      if ((st_op == OP_SH) && addr[0])
         legal = 1'b0;
      if (!in_dm && !in_dev)
         legal = 1'b0;
      // device registers only accept full-word writes
      if (in_dev && (st_op != OP_SW))
         legal = 1'b0;
   end

   always_comb begin
      next_be    = 4'b1111;
      next_wdata = wdata_in;
      case (st_op)
         OP_SH: begin
            next_be    = addr[1] ? 4'b1100 : 4'b0011;
            next_wdata = {2{wdata_in[15:0]}};
         end
         OP_SB: begin
            next_be    = 4'b0001 << addr[1:0];
            next_wdata = {4{wdata_in[7:0]}};
         end
         default: begin
            next_be    = 4'b1111;
            next_wdata = wdata_in;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bus_valid <= 1'b0;
         bus_addr  <= 32'd0;
         bus_be    <= 4'd0;
         bus_wdata <= 32'd0;
         exc_ades  <= 1'b0;
         exc_addr  <= 32'd0;
      end else begin
         exc_ades <= 1'b0;
         if (accept && legal) begin
            state     <= PEND;
            bus_valid <= 1'b1;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= next_be;
            bus_wdata <= next_wdata;
         end else begin
            if (accept) begin
               exc_ades <= 1'b1;
               exc_addr <= addr;
            end
            // payload registers keep their last value after the drain
            if ((state == PEND) && bus_ready) begin
               state     <= IDLE;
               bus_valid <= 1'b0;
            end
         end
      end
   end

endmodule
